// File: rtl/button_event_decoder.sv
// Turns a debounced, clk-synchronous button level into one-cycle press/release/
// short/long/repeat pulses, a held level and a wrapping press counter.
module button_event_decoder #(
  parameter int LONG_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int CNT_W         = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_level,
  input  logic       repeat_en,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_press,
  output logic       long_press,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHORT = 2'd1;
  localparam logic [1:0] S_LONG  = 2'd2;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             btn_q;
  logic             rise;

  assign rise = btn_level & ~btn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      // btn_q preset high so a button held through reset needs a fresh press
      btn_q         <= 1'b1;
      state         <= S_IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      btn_q         <= btn_level;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      // held lags state by one cycle so it still covers the release_pulse cycle
      held          <= (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (rise) begin
            state       <= S_SHORT;
            cnt         <= '0;
            press_pulse <= 1'b1;
            held        <= 1'b1;
            press_count <= press_count + 8'd1;
          end
        end
        S_SHORT: begin
          if (!btn_level) begin
            state         <= S_IDLE;
            release_pulse <= 1'b1;
            short_press   <= 1'b1;
          end else if (cnt == LONG_LAST) begin
            state      <= S_LONG;
            cnt        <= '0;
            long_press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LONG: begin
          if (!btn_level) begin
            state         <= S_IDLE;
            release_pulse <= 1'b1;
          end else if (cnt == REP_LAST) begin
            // counter wraps even with repeat disabled to keep repeat phase fixed
            cnt          <= '0;
            repeat_pulse <= repeat_en;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
Sits directly downstream of the button debouncer. It consumes the debounced, clk-synchronous button level and turns it into one-cycle event pulses: press, release, short press, long press and auto-repeat while held. It also keeps a wrapping press counter for the LED/demo logic. Everything is on a single clock domain, with no combinational path from input to output.

Parameters:
LONG_CYCLES, 25_000_000, number of held cycles after the press pulse before long_press fires (0.5 s at 50 MHz); must be >= 2.
REPEAT_CYCLES, 5_000_000, period of repeat_pulse once in the long-hold state; must be >= 2.
CNT_W, 25, hold-counter width; must satisfy 2^CNT_W > max(LONG_CYCLES, REPEAT_CYCLES).

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
btn_level  input  1  debounced button level (1 = pressed), already synchronous to clk.
repeat_en  input  1  1 = allow repeat_pulse while in the long-hold state.
press_pulse  output  1  one-cycle pulse on each accepted press.
release_pulse  output  1  one-cycle pulse on release of an accepted press.
short_press  output  1  one-cycle pulse on release before the long threshold.
long_press  output  1  one-cycle pulse when the hold reaches LONG_CYCLES.
repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES while held in the long-hold state.
held  output  1  level; 1 while state != IDLE.
press_count  output  8  count of press_pulse events, wraps 255 -> 0.

Behaviour:
- All outputs are registered. Reset values: every pulse output = 0, held = 0, press_count = 0, state = IDLE, hold counter = 0.
- Edge detect: btn_q <= btn_level every cycle. rise = btn_level & ~btn_q.
- During rst, btn_q loads 1. A button held through reset release therefore produces no press; it must be released and pressed again.
- The FSM has three states: IDLE, SHORT, LONG. All pulse outputs default to 0 on each cycle unless set below.
- IDLE:
  - On rise: state <= SHORT, cnt <= 0, press_pulse <= 1, press_count <= press_count + 1 (mod 256).
  - Otherwise stay in IDLE.
- SHORT:
  - If btn_level = 0: state <= IDLE, release_pulse <= 1, short_press <= 1.
  - Else if cnt == LONG_CYCLES-1: state <= LONG, cnt <= 0, long_press <= 1.
  - Else cnt <= cnt + 1.
  - Release has priority over the threshold on the same cycle, so the result is a short press.
- LONG:
  - If btn_level = 0: state <= IDLE, release_pulse <= 1, and no short_press.
  - Else if cnt == REPEAT_CYCLES-1: cnt <= 0, and repeat_pulse <= repeat_en.
  - Else cnt <= cnt + 1.
  - The counter runs regardless of repeat_en, so the repeat phase stays fixed relative to long_press.
- Timing, with press_pulse high in cycle P:
  - long_press is high in cycle P+LONG_CYCLES.
  - The first repeat_pulse is high in cycle P+LONG_CYCLES+REPEAT_CYCLES, then one every REPEAT_CYCLES cycles.
  - release_pulse is high 1 cycle after the first cycle btn_level is sampled low.
- held = 1 from the cycle press_pulse is high until the cycle release_pulse is high; it is 0 in the cycle after release_pulse.
- Coincidence rules:
  - release_pulse and short_press coincide.
  - press_pulse never coincides with any other pulse.
  - long_press and repeat_pulse never coincide.
- A new press is accepted in IDLE only. Minimum re-press spacing is 1 low cycle.
- Reset mid-hold aborts the press: no release_pulse or short_press is emitted and press_count clears.
- The hold counter never exceeds max(LONG_CYCLES, REPEAT_CYCLES)-1, so no overflow is possible.

Test Plan:
All scenarios use LONG_CYCLES=8, REPEAT_CYCLES=4.
1. Short press: hold btn_level 1 for 5 cycles, then 0 -> press_pulse in cycle P; release_pulse and short_press together in cycle P+5; no long_press; press_count = 1.
2. Long hold with repeat_en = 1: hold for 20 cycles -> long_press at P+8; repeat_pulse at P+12 and P+16; at release, release_pulse only (short_press stays 0); held deasserts the cycle after release_pulse.
3. Same hold as scenario 2 with repeat_en = 0 -> long_press at P+8; no repeat_pulse; release_pulse on release.
4. Release exactly at threshold: btn_level 0 sampled on the cycle where cnt == 7 -> short_press and release_pulse; long_press never fires.
5. Reset behaviour:
   - Button held through reset, then 10 more cycles -> no press_pulse.
   - Release and re-press -> press_pulse; press_count = 1.
   - Reset asserted mid-hold -> no release_pulse; press_count = 0.
6. Wrap-around: 256 presses of 1-cycle high / 1-cycle low -> press_count reads 0 after the last press; 257th press -> press_count = 1.
